// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit scheduler: FSM state
// encoding, data-bit count, line levels and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler: requests and bytes in,
// grant, in-flight source, busy and the serial line out.
interface uart_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data_in;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      src_id;
  logic                 busy;
  logic                 serial_out;

  modport master (
    output req, data_in,
    input  grant, src_id, busy, serial_out
  );

  modport slave (
    input  req, data_in,
    output grant, src_id, busy, serial_out
  );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: picks the first set request searching upward from
// last+1 (mod NUM_REQ); grant is one-hot and gated by en.
module uart_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned cand;
      cand = (32'(last) + k) % NUM_REQ;
      if (!found && req[ID_W'(cand)]) begin
        found = 1'b1;
        idx   = ID_W'(cand);
      end
    end
    if (en && found) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: arbitrates requesters in IDLE and
// serializes the granted byte. Optional parity: UART_TX_SCHEDULER_PARITY_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_scheduler_if.slave bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [ID_W-1:0]           src_q, src_d;
  logic [ID_W-1:0]           last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      line_q, line_d;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_en;
  logic               tc;

  // Arbitration only while idle and out of reset, so a reset never grants.
  assign arb_en = (state_q == IDLE) && !rst;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req),
    .last  (last_q),
    .en    (arb_en),
    .grant (grant_c),
    .idx   (arb_idx)
  );

  assign tc = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    src_d   = src_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|grant_c) begin
          state_d = START;
          shift_d = bus.data_in[{arb_idx, 3'b000} +: UART_DATA_BITS];
          src_d   = arb_idx;
          last_d  = arb_idx;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tc) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_SCHEDULER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
      STOP: begin
        if (tc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Line level and busy follow the next state so both are registered.
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   line_d = UART_START_LVL;
      DATA:    line_d = shift_d[bit_d];
      PARITY:  line_d = even_parity(shift_d);
      STOP:    line_d = UART_STOP_LVL;
      default: line_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      src_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      line_q  <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      src_q   <= src_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      line_q  <= line_d;
    end
  end

  assign bus.grant      = grant_c;
  assign bus.src_id     = src_q;
  assign bus.busy       = busy_q;
  assign bus.serial_out = line_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random requesters,
// checked cycle by cycle against a queue-of-line-bits reference model.
module tb_uart_tx_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CLKS    = 4;
`ifdef UART_TX_SCHEDULER_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned FRAME_CYC = FRAME_BITS * CLKS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CLKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  // Reference model: expected line level for every upcoming busy cycle.
  bit                 exp_line[$];
  int                 m_last = NUM_REQ - 1;
  int                 m_src  = 0;
  logic [NUM_REQ-1:0] m_gnt  = '0;

  logic               obs_busy;
  logic [NUM_REQ-1:0] obs_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic push_frame(input logic [7:0] b);
    repeat (CLKS) exp_line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CLKS) exp_line.push_back(b[i]);
`ifdef UART_TX_SCHEDULER_PARITY_EN
    repeat (CLKS) exp_line.push_back(^b);
`endif
    repeat (CLKS) exp_line.push_back(1'b1);
  endtask

  task automatic model_step();
    logic [NUM_REQ-1:0] eg;
    int w;
    bit e;
    eg = '0;
    chk("src_id", 32'(bus.src_id), 32'(m_src));
    if (exp_line.size() == 0) begin
      chk("line_idle", 32'(bus.serial_out), 32'(1));
      chk("busy_idle", 32'(bus.busy), 32'(0));
      w = rr_pick(bus.req, m_last);
      if (w >= 0) begin
        eg[w]  = 1'b1;
        push_frame(bus.data_in[8*w +: 8]);
        m_last = w;
        m_src  = w;
      end
      chk("grant", 32'(bus.grant), 32'(eg));
    end else begin
      e = exp_line.pop_front();
      chk("line", 32'(bus.serial_out), 32'(e));
      chk("busy", 32'(bus.busy), 32'(1));
      chk("grant_in_frame", 32'(bus.grant), 32'(0));
    end
    m_gnt = eg;
  endtask

  // One clock: observe at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      chk("rst_line", 32'(bus.serial_out), 32'(1));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_grant", 32'(bus.grant), 32'(0));
      chk("rst_src", 32'(bus.src_id), 32'(0));
      m_gnt = '0;
    end else begin
      model_step();
    end
    obs_busy  = bus.busy;
    obs_grant = bus.grant;
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    chk("arst_line", 32'(bus.serial_out), 32'(1));
    chk("arst_busy", 32'(bus.busy), 32'(0));
    exp_line.delete();
    m_last = NUM_REQ - 1;
    m_src  = 0;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int idx, output int at);
    idx = -1;
    at  = 0;
    for (int k = 0; k < 4 * FRAME_CYC; k++) begin
      tick();
      if (obs_grant != '0) begin
        idx = onehot_idx(obs_grant);
        at  = cycle;
        return;
      end
    end
    chk("grant_timeout", 32'(obs_grant), 32'(1));
  endtask

  task automatic frame_len(output int n);
    n = 0;
    for (int k = 0; k < 4 * FRAME_CYC; k++) begin
      tick();
      if (obs_busy) n++;
      else return;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, t, tprev, n;
    bus.req     = '0;
    bus.data_in = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Idle line with no requests.
    repeat (100) tick();

    // Single byte 0xA5 from requester 2.
    bus.data_in[23:16] = 8'hA5;
    bus.req[2]         = 1'b1;
    wait_grant(idx, t);
    chk("a5_grant_id", 32'(idx), 32'(2));
    bus.req = '0;
    frame_len(n);
    chk("a5_busy_len", 32'(n), 32'(FRAME_CYC));

    // All requesters held: rotation and back-to-back spacing.
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) bus.data_in[8*i +: 8] = 8'($urandom);
    bus.req = '1;
    tprev   = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(idx, t);
      chk("rr_order", 32'(idx), 32'(g % NUM_REQ));
      if (g > 0) chk("rr_gap", 32'(t - tprev), 32'(FRAME_CYC + 1));
      tprev = t;
    end
    bus.req = '0;
    frame_len(n);

    // After requester 1, requests on 1 and 3: 3 wins.
    bus.req = 4'b0010;
    wait_grant(idx, t);
    chk("prio_first", 32'(idx), 32'(1));
    bus.req = '0;
    frame_len(n);
    bus.req = 4'b1010;
    wait_grant(idx, t);
    chk("prio_after_1", 32'(idx), 32'(3));
    bus.req = '0;
    frame_len(n);

    // Reset during data bit 3, then requester 0 wins over 1.
    bus.data_in[15:8] = 8'h3C;
    bus.req = 4'b0010;
    wait_grant(idx, t);
    chk("abort_first", 32'(idx), 32'(1));
    bus.req = 4'b0011;
    repeat (4 * CLKS + 1) tick();
    do_reset(2);
    wait_grant(idx, t);
    chk("post_reset_winner", 32'(idx), 32'(0));
    bus.req = '0;
    frame_len(n);

    // All-ones byte: frame length and no stray bits.
    bus.data_in[7:0] = 8'hFF;
    bus.req[0]       = 1'b1;
    wait_grant(idx, t);
    chk("ff_grant_id", 32'(idx), 32'(0));
    bus.req = '0;
    frame_len(n);
    chk("ff_busy_len", 32'(n), 32'(FRAME_CYC));

    // Random requesters: hold until granted, sometimes re-request or withdraw.
    repeat (3000) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
          else bus.data_in[8*i +: 8] = 8'($urandom);
        end else if (!bus.req[i]) begin
          if ($urandom_range(29, 0) == 0) begin
            bus.data_in[8*i +: 8] = 8'($urandom);
            bus.req[i]            = 1'b1;
          end
        end else if ($urandom_range(199, 0) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      if ($urandom_range(999, 0) == 0) do_reset(1);
    end
    bus.req = '0;
    repeat (FRAME_CYC + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmit line between several byte-producing requesters. A round-robin arbiter picks the next requester, and a frame sequencer serializes the granted byte onto `serial_out` as idle, start, 8 data bits, optional parity and stop, at a fixed baud rate. It sits between the on-chip byte sources and the UART1 pin, and replaces direct driving of `idle_bit`/`start_bit`/`tx1`/`parity_bit`/`stop_bit`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, `NUM_REQ`: per-requester transmit request, level, held until granted.
- `data_in`, in, `NUM_REQ*8`: byte for requester i in bits [8i+7:8i].
- `grant`, out, `NUM_REQ`: one-hot, one-cycle pulse when requester's byte is accepted.
- `src_id`, out, `$clog2(NUM_REQ)`: index of the requester whose frame is in flight.
- `busy`, out, 1: high from the cycle after grant until the end of the stop bit.
- `serial_out`, out, 1: UART line, idle high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `serial_out`=1.
  - If any `req` is high, grant the first set request searching from `last+1` modulo `NUM_REQ`.
  - Latch that requester's byte into the shift register and set `src_id` and `last`.
  - Go to START.
- START: `serial_out`=0 for `CLKS_PER_BIT` cycles.
- DATA:
  - 8 bits, LSB first, each held `CLKS_PER_BIT` cycles.
  - A 3-bit counter indexes the bits.
  - After bit 7, go to PARITY (parity compiled in) or STOP.
- PARITY: even parity, i.e. XOR of the 8 latched bits, held one bit time.
- STOP: `serial_out`=1 for one bit time, then IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1.
  - Cleared on every state entry.
  - A bit ends on terminal count.
- `req` deasserted before grant: nothing sent, no error.
- `req` changes during a frame: ignored. Arbitration happens only in IDLE.
- Requester granted may keep `req` high. It re-competes in the next IDLE at lowest priority.
- Reset values: state IDLE, `serial_out`=1, `grant`=0, `busy`=0, `src_id`=0, `last`=`NUM_REQ`-1 (so requester 0 has first priority), shift register 0.
- Reset mid-frame: line returns high immediately (asynchronous), frame aborted, no grant re-issued.

## Timing
- Grant at cycle T, the IDLE cycle in which `req` is seen. `data_in` is sampled at the T edge.
- START occupies cycles T+1 .. T+C, where C=`CLKS_PER_BIT`.
- Data bit i occupies cycles T+1+(1+i)·C .. T+(2+i)·C.
- Frame length: 11·C cycles with parity, 10·C without.
- After STOP, at least one IDLE cycle (line high). Back-to-back frames start every 11·C+1 (10·C+1) cycles.
- `busy` is high exactly during START..STOP.

## Configuration
- Macro: `UART_TX_SCHEDULER_PARITY_EN`.
  - Defined: the PARITY state is inserted and frames are 11 bits.
  - Undefined: the PARITY state is absent, DATA goes directly to STOP, and frames are 10 bits.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constant `UART_DATA_BITS`=8;
  - line-level constants `UART_IDLE_LVL`=1, `UART_START_LVL`=0, `UART_STOP_LVL`=1.
- Sub-module `uart_rr_arbiter`:
  - parameterized by `NUM_REQ`;
  - inputs `req`, `last`, `en`;
  - outputs one-hot `grant` and the encoded index.

## Test plan
- Reset, then `req`=0: `serial_out`=1, `busy`=0, `grant`=0 for 100 cycles.
- C=4, parity on, `req[2]`=1, byte 0xA5:
  - `grant`=0100 for 1 cycle, `src_id`=2;
  - line 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1, 4 cycles each;
  - total 44 cycles busy.
- All four `req` held high: grants in order 0,1,2,3,0, each 45 cycles apart at C=4 with parity.
- `req[1]` and `req[3]` high after requester 1 was last granted: requester 3 is granted first.
- `rst` pulsed during DATA bit 3: `serial_out`=1 and `busy`=0 within the same cycle; after release, requester 0 wins.
- Parity macro undefined, byte 0xFF, C=4: frame 40 cycles, no parity bit, stop directly after bit 7.
